// File: rtl/elevator_pkg.sv
// Shared types and default timing for the elevator controller and door actuator.
// Holds the door FSM state enum, controller state encodings and a door-busy helper.
package elevator_pkg;

    typedef enum logic [2:0] {
        CLOSED,
        OPENING,
        OPEN_DWELL,
        CLOSING,
        FAULT
    } door_state_t;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_MOVE_UP,
        CTRL_MOVE_DOWN,
        CTRL_DOOR_STOP
    } ctrl_state_t;

    localparam int DEF_DWELL_CYCLES   = 50;
    localparam int DEF_MOTION_TIMEOUT = 20;
    localparam int DEF_MAX_REOPEN     = 3;
    localparam int DEF_CNT_W          = 8;

    // Door states in which the controller must stay in DOOR_STOP.
    function automatic logic is_door_busy(door_state_t s);
        return s inside {OPENING, OPEN_DWELL, CLOSING, FAULT};
    endfunction

endpackage

// File: rtl/door_timer.sv
// Shared dwell / motion counter for the door actuator.
// Ports: i_clr, i_load(i_load_val), i_inc, i_dec controls; o_zero and o_match (== i_limit) flags.
module door_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_zero,
    output logic             o_match
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero  = (r_cnt == '0);
    assign o_match = (r_cnt == i_limit);

endmodule

// File: rtl/elevator_door_actuator.sv
// Door motor actuator: turns controller door commands into motor drive with dwell,
// motion timeouts, reopen limit, move interlock and a latched fault.
// Ports: i_clk, i_rst, controller cmds (i_door_open_cmd, i_door_close_cmd, i_move),
//   cab buttons, i_obstruct, limit switches; outputs o_motor_open, o_motor_close,
//   o_hold_open, o_door_locked, o_fault.
module elevator_door_actuator
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES,
    parameter int MOTION_TIMEOUT = DEF_MOTION_TIMEOUT,
    parameter int MAX_REOPEN     = DEF_MAX_REOPEN,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_door_open_cmd,
    input  logic i_door_close_cmd,
    input  logic i_move,
    input  logic i_open_btn,
    input  logic i_close_btn,
    input  logic i_obstruct,
    input  logic i_lim_open,
    input  logic i_lim_closed,
    output logic o_motor_open,
    output logic o_motor_close,
    output logic o_hold_open,
    output logic o_door_locked,
    output logic o_fault
);

    localparam int RC_W = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOT_LIM  = CNT_W'(MOTION_TIMEOUT - 1);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_REOPEN);

    door_state_t     r_state;
    door_state_t     w_nxt;
    logic [RC_W-1:0] r_reopen;
    logic            r_motor_open;
    logic            r_motor_close;
    logic            r_hold_open;
    logic            r_fault;

    logic w_clr, w_load, w_inc, w_dec;
    logic w_zero, w_match;
    logic w_rc_inc, w_rc_clr;
    logic w_reopen_req;
    logic w_global_err;

    // door_close_cmd is not needed: closing is driven by dwell expiry or close_btn.
    logic w_unused;
    assign w_unused = i_door_close_cmd;

    assign w_reopen_req = i_obstruct || i_open_btn;
    assign w_global_err = (i_lim_open && i_lim_closed) ||
                          (i_move && (r_state != CLOSED));

    always_comb begin
        w_nxt    = r_state;
        w_clr    = 1'b0;
        w_load   = 1'b0;
        w_inc    = 1'b0;
        w_dec    = 1'b0;
        w_rc_inc = 1'b0;
        w_rc_clr = 1'b0;
        if (r_state != FAULT && w_global_err) begin
            w_nxt = FAULT;
            w_clr = 1'b1;
        end else begin
            case (r_state)
                CLOSED: begin
                    if ((i_door_open_cmd || i_open_btn) && !i_move) begin
                        w_nxt = OPENING;
                        w_clr = 1'b1;
                    end
                end
                OPENING: begin
                    if (i_lim_open) begin
                        w_nxt  = OPEN_DWELL;
                        w_load = 1'b1;
                    end else if (w_match) begin
                        w_nxt = FAULT;
                        w_clr = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                OPEN_DWELL: begin
                    if (w_reopen_req) begin
                        w_load = 1'b1;
                    end else if (i_close_btn || w_zero) begin
                        w_nxt = CLOSING;
                        w_clr = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                CLOSING: begin
                    // A reopen request outranks reaching the closed limit.
                    if (w_reopen_req) begin
                        w_clr = 1'b1;
                        if (r_reopen == RC_MAX) begin
                            w_nxt = FAULT;
                        end else begin
                            w_nxt    = OPENING;
                            w_rc_inc = 1'b1;
                        end
                    end else if (i_lim_closed) begin
                        w_nxt    = CLOSED;
                        w_clr    = 1'b1;
                        w_rc_clr = 1'b1;
                    end else if (w_match) begin
                        w_nxt = FAULT;
                        w_clr = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                default: w_nxt = r_state;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= CLOSED;
            r_reopen      <= '0;
            r_motor_open  <= 1'b0;
            r_motor_close <= 1'b0;
            r_hold_open   <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_rc_clr) begin
                r_reopen <= '0;
            end else if (w_rc_inc && r_reopen != RC_MAX) begin
                r_reopen <= r_reopen + RC_W'(1);
            end
            r_motor_open  <= (w_nxt == OPENING);
            r_motor_close <= (w_nxt == CLOSING);
            r_hold_open   <= is_door_busy(w_nxt);
            r_fault       <= (w_nxt == FAULT);
        end
    end

    door_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_clr),
        .i_load    (w_load),
        .i_load_val(DWELL_LD),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .i_limit   (MOT_LIM),
        .o_zero    (w_zero),
        .o_match   (w_match)
    );

    assign o_motor_open  = r_motor_open;
    assign o_motor_close = r_motor_close;
    assign o_hold_open   = r_hold_open;
    assign o_fault       = r_fault;
    assign o_door_locked = (r_state == CLOSED) && i_lim_closed;

endmodule

// File: tb/tb_elevator_door_actuator.sv
// Bench for elevator_door_actuator: directed scenarios plus random stimulus,
// all outputs compared each cycle against a behavioural door model.
module tb_elevator_door_actuator;

    localparam int D  = 5;
    localparam int MT = 20;
    localparam int MR = 3;

    localparam int P_CLOSED  = 0;
    localparam int P_OPENING = 1;
    localparam int P_DWELL   = 2;
    localparam int P_CLOSING = 3;
    localparam int P_FAULT   = 4;

    typedef struct {
        int ph;
        int elapsed;
        int left;
        int reopens;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic doc = 1'b0, dcc = 1'b0, mv = 1'b0;
    logic obtn = 1'b0, cbtn = 1'b0, obs = 1'b0;
    logic lo = 1'b0, lc = 1'b1;
    logic o_motor_open, o_motor_close, o_hold_open, o_door_locked, o_fault;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;
    mdl_t m = '{P_CLOSED, 0, 0, 0};

    always #5 clk = ~clk;

    elevator_door_actuator #(
        .DWELL_CYCLES  (D),
        .MOTION_TIMEOUT(MT),
        .MAX_REOPEN    (MR),
        .CNT_W         (8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_door_open_cmd (doc),
        .i_door_close_cmd(dcc),
        .i_move          (mv),
        .i_open_btn      (obtn),
        .i_close_btn     (cbtn),
        .i_obstruct      (obs),
        .i_lim_open      (lo),
        .i_lim_closed    (lc),
        .o_motor_open    (o_motor_open),
        .o_motor_close   (o_motor_close),
        .o_hold_open     (o_hold_open),
        .o_door_locked   (o_door_locked),
        .o_fault         (o_fault)
    );

    // Door behaviour in terms of elapsed motion cycles and dwell cycles left.
    function automatic mdl_t mstep(mdl_t c, logic r, logic dopen, logic move,
                                   logic ob, logic cb, logic ost,
                                   logic lop, logic lcl);
        mdl_t n = c;
        if (r) begin
            n = '{P_CLOSED, 0, 0, 0};
        end else if (c.ph != P_FAULT &&
                     ((lop && lcl) || (move && c.ph != P_CLOSED))) begin
            n.ph = P_FAULT;
        end else if (c.ph == P_CLOSED) begin
            if ((dopen || ob) && !move) begin
                n.ph = P_OPENING;
                n.elapsed = 0;
            end
        end else if (c.ph == P_OPENING) begin
            if (lop) begin
                n.ph = P_DWELL;
                n.left = D;
            end else begin
                n.elapsed = c.elapsed + 1;
                if (n.elapsed == MT) n.ph = P_FAULT;
            end
        end else if (c.ph == P_DWELL) begin
            if (ost || ob) begin
                n.left = D;
            end else if (cb || c.left == 1) begin
                n.ph = P_CLOSING;
                n.elapsed = 0;
            end else begin
                n.left = c.left - 1;
            end
        end else if (c.ph == P_CLOSING) begin
            if (ost || ob) begin
                if (c.reopens == MR) begin
                    n.ph = P_FAULT;
                end else begin
                    n.reopens = c.reopens + 1;
                    n.ph = P_OPENING;
                    n.elapsed = 0;
                end
            end else if (lcl) begin
                n.ph = P_CLOSED;
                n.reopens = 0;
            end else begin
                n.elapsed = c.elapsed + 1;
                if (n.elapsed == MT) n.ph = P_FAULT;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= mstep(m, rst, doc, mv, obtn, cbtn, obs, lo, lc);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("motor_open", int'(o_motor_open), int'(m.ph == P_OPENING));
            chk("motor_close", int'(o_motor_close), int'(m.ph == P_CLOSING));
            chk("hold_open", int'(o_hold_open),
                int'(m.ph != P_CLOSED));
            chk("fault", int'(o_fault), int'(m.ph == P_FAULT));
            chk("door_locked", int'(o_door_locked),
                int'(m.ph == P_CLOSED && lc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        doc = 0; dcc = 0; mv = 0; obtn = 0; cbtn = 0; obs = 0;
        lo = 0; lc = 1;
        rst = 1;
        cyc();
        rst = 0;
    endtask

    // From CLOSED: two OPENING cycles, then lands in the first dwell cycle.
    task automatic open_door();
        doc = 1;
        cyc();
        doc = 0;
        lc = 0;
        cyc();
        lo = 1;
        cyc();
    endtask

    int cnt;
    int g;
    int fa;
    int r;

    initial begin
        cyc();
        chk_on = 1'b1;
        do_reset();
        chk("rst_motor_open", int'(o_motor_open), 0);
        chk("rst_hold_open", int'(o_hold_open), 0);
        chk("rst_fault", int'(o_fault), 0);
        chk("rst_door_locked", int'(o_door_locked), 1);

        // normal cycle
        doc = 1;
        cyc();
        cnt = int'(o_motor_open);
        doc = 0;
        lc = 0;
        cyc();
        cnt += int'(o_motor_open);
        cyc();
        cnt += int'(o_motor_open);
        lo = 1;
        cyc();
        cnt += int'(o_motor_open);
        chk("t1_open_cycles", cnt, 3);
        cnt = 0;
        g = 0;
        while (!o_motor_close && g < 30) begin
            if (o_hold_open && !o_motor_open && !o_fault) cnt++;
            cyc();
            g++;
        end
        chk("t1_dwell_cycles", cnt, D);
        lo = 0;
        cnt = int'(o_motor_close);
        cyc();
        cnt += int'(o_motor_close);
        cyc();
        cnt += int'(o_motor_close);
        cyc();
        cnt += int'(o_motor_close);
        lc = 1;
        cyc();
        cnt += int'(o_motor_close);
        chk("t1_close_cycles", cnt, 4);
        chk("t1_hold_low", int'(o_hold_open), 0);
        chk("t1_locked", int'(o_door_locked), 1);

        // dwell extend, then close-button skip
        open_door();
        cyc();
        cyc();
        obtn = 1;
        cyc();
        obtn = 0;
        cnt = 0;
        g = 0;
        while (!o_motor_close && g < 30) begin
            cnt++;
            cyc();
            g++;
        end
        chk("t2_dwell_extend", cnt, D);
        lo = 0;
        lc = 1;
        cyc();
        open_door();
        cbtn = 1;
        cyc();
        cbtn = 0;
        chk("t2_close_btn_skip", int'(o_motor_close), 1);
        lo = 0;
        lc = 1;
        cyc();

        // reopen limit
        open_door();
        cbtn = 1;
        cyc();
        cbtn = 0;
        lo = 0;
        for (int k = 1; k <= MR; k++) begin
            obs = 1;
            cyc();
            obs = 0;
            chk("t3_reopen", int'(o_motor_open), 1);
            lo = 1;
            cyc();
            cbtn = 1;
            cyc();
            cbtn = 0;
            lo = 0;
        end
        obs = 1;
        cyc();
        obs = 0;
        chk("t3_fault", int'(o_fault), 1);
        chk("t3_motors_off", int'(o_motor_open | o_motor_close), 0);
        for (int k = 0; k < 8; k++) begin
            doc = 1'($urandom);
            cbtn = 1'($urandom);
            lc = 1'($urandom);
            cyc();
        end
        chk("t3_fault_held", int'(o_fault), 1);

        // opening timeout
        do_reset();
        doc = 1;
        cyc();
        doc = 0;
        lc = 0;
        cnt = 0;
        while (!o_fault && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("t4_timeout_cycles", cnt, MT);

        // interlock and sensor error
        do_reset();
        open_door();
        mv = 1;
        cyc();
        mv = 0;
        chk("t5_move_dwell", int'(o_fault), 1);
        do_reset();
        lo = 1;
        cyc();
        lo = 0;
        chk("t5_both_limits", int'(o_fault), 1);
        do_reset();
        doc = 1;
        mv = 1;
        cyc();
        cyc();
        chk("t5_move_blocks", int'(o_motor_open), 0);
        chk("t5_still_locked", int'(o_door_locked), 1);
        doc = 0;
        mv = 0;

        // reset mid-motion, reopen beats closed limit
        open_door();
        cbtn = 1;
        cyc();
        cbtn = 0;
        lo = 0;
        chk("t6_closing", int'(o_motor_close), 1);
        rst = 1;
        cyc();
        rst = 0;
        chk("t6_rst_motor", int'(o_motor_close), 0);
        chk("t6_rst_fault", int'(o_fault), 0);
        lc = 1;
        cyc();
        open_door();
        cbtn = 1;
        cyc();
        cbtn = 0;
        lo = 0;
        obs = 1;
        lc = 1;
        cyc();
        obs = 0;
        lc = 0;
        chk("t6_obs_wins", int'(o_motor_open), 1);

        // random
        do_reset();
        fa = 0;
        for (int i = 0; i < 3000; i++) begin
            fa = (m.ph == P_FAULT) ? fa + 1 : 0;
            rst = (fa > 3) || ($urandom_range(0, 199) == 0);
            doc = ($urandom_range(0, 4) == 0);
            dcc = ($urandom_range(0, 4) == 0);
            mv = ($urandom_range(0, 49) == 0);
            obs = ($urandom_range(0, 11) == 0);
            obtn = ($urandom_range(0, 24) == 0);
            cbtn = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 99);
            lo = (r < 30) || (r == 99);
            lc = (r >= 30 && r < 70) || (r == 99);
            cyc();
        end
        rst = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_door_actuator.md
Name: elevator_door_actuator

Overview:
- Downstream of the elevator FSM controller. Consumes its door_open / door_close / move outputs and drives the physical door motor using limit switches, an obstruction sensor and cab buttons.
- Returns hold_open to the controller's open input, which keeps the controller stopped until the door is proven closed.
- Enforces dwell timing, motion timeouts, a reopen limit and a move interlock. Latches any fault until reset.

Parameters:
- DWELL_CYCLES, 50, cycles the door stays fully open before auto-close (must be 2 to 2**CNT_W).
- MOTION_TIMEOUT, 20, maximum cycles allowed in OPENING or CLOSING before a limit switch is reached (must be 2 to 2**CNT_W).
- MAX_REOPEN, 3, obstruction/open-button reopens allowed per door cycle before FAULT.
- CNT_W, 8, shared timer width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- door_open_cmd  in  1  controller door_open (level)
- door_close_cmd  in  1  controller door_close (level)
- move  in  1  controller move (cab in motion)
- open_btn  in  1  cab door-open button (level, pre-synchronised)
- close_btn  in  1  cab door-close button (level)
- obstruct  in  1  light-curtain obstruction (level)
- lim_open  in  1  door fully-open limit switch
- lim_closed  in  1  door fully-closed limit switch
- motor_open  out  1  drive door toward open
- motor_close  out  1  drive door toward closed
- hold_open  out  1  to controller open input; high = do not leave DOOR_STOP
- door_locked  out  1  door proven closed, cab may move
- fault  out  1  latched fault

Behaviour:
- Implementation style:
  - Moore FSM with a registered state.
  - All outputs decode the state, and are registered or glitch-free.
  - Inputs are sampled on the clk edge. A state change takes effect 1 cycle after the causing input.
- Reset (rst high at an edge, including mid-motion):
  - state=CLOSED, timer=0, reopen_cnt=0.
  - Outputs: motor_open=0, motor_close=0, hold_open=0, fault=0, door_locked=lim_closed.
- Global rule, checked first in every state except FAULT:
  - lim_open && lim_closed -> FAULT.
  - move high in any state other than CLOSED -> FAULT (interlock violation).
- Output decode by state:
  - motor_open=1 only in OPENING.
  - motor_close=1 only in CLOSING. The two motor outputs are never both 1.
  - hold_open=1 in OPENING, OPEN_DWELL, CLOSING and FAULT.
  - door_locked = (state==CLOSED) && lim_closed.
- CLOSED:
  - door_open_cmd && !move -> OPENING, timer=0.
  - open_btn && !move -> OPENING.
  - door_close_cmd is ignored.
  - If lim_closed drops while CLOSED, stay in CLOSED with door_locked=0 (the controller sees this).
- OPENING:
  - lim_open -> OPEN_DWELL, timer=DWELL_CYCLES-1.
  - Otherwise, when timer==MOTION_TIMEOUT-1 -> FAULT.
  - Otherwise timer+1.
- OPEN_DWELL, priority high to low:
  1. obstruct or open_btn -> reload timer=DWELL_CYCLES-1.
  2. close_btn -> CLOSING, timer=0.
  3. timer==0 -> CLOSING, timer=0.
  4. Otherwise timer-1.
  - With no buttons, the state lasts exactly DWELL_CYCLES cycles.
- CLOSING, priority high to low:
  1. obstruct or open_btn:
     - If reopen_cnt==MAX_REOPEN -> FAULT.
     - Else reopen_cnt+1 -> OPENING, timer=0.
  2. lim_closed -> CLOSED, reopen_cnt=0.
  3. timer==MOTION_TIMEOUT-1 -> FAULT.
  4. Otherwise timer+1.
  - If obstruct and lim_closed arrive in the same cycle, the reopen wins.
- FAULT:
  - Both motors 0, fault=1, hold_open=1.
  - Exits only on rst.
- Width rules:
  - timer is CNT_W bits and never wraps; it is reloaded or cleared on every state entry.
  - reopen_cnt is $clog2(MAX_REOPEN+1) bits and saturates at MAX_REOPEN.
- Controller's door_open_cmd may fall while in OPEN_DWELL: ignored, the dwell continues.

Decomposition:
- elevator_pkg holds:
  - door_state_t enum: CLOSED, OPENING, OPEN_DWELL, CLOSING, FAULT.
  - Default timing constants.
  - The controller state encodings, shared with the controller.
- One sub-module, door_timer:
  - CNT_W-bit counter with load, clear, increment and decrement.
  - Outputs a zero flag and a match-against-limit flag.
  - Instantiated once.

Test Plan:
- Normal cycle (DWELL_CYCLES=5, MOTION_TIMEOUT=20): door_open_cmd=1, lim_open rises 3 cycles after OPENING entry, no buttons, lim_closed rises 4 cycles into CLOSING -> motor_open high 3 cycles, OPEN_DWELL lasts exactly 5 cycles, motor_close high 4 cycles, hold_open falls and door_locked=1 on return to CLOSED.
- Dwell extend/skip: open_btn pulsed at dwell count 2 -> timer reloads to 4 and dwell lasts 5 more cycles; close_btn in the first dwell cycle -> CLOSING on the next edge.
- Obstruction reopen and limit (MAX_REOPEN=3): obstruct during CLOSING 3 times -> 3 OPENING re-entries with reopen_cnt=1,2,3; a 4th obstruct -> FAULT, motors 0, fault=1, held there until rst.
- Timeout: hold lim_open=0 through OPENING -> FAULT exactly 20 cycles after OPENING entry.
- Interlock and sensor error: move=1 during OPEN_DWELL -> FAULT next cycle; lim_open=lim_closed=1 in CLOSED -> FAULT; door_open_cmd with move=1 in CLOSED -> stays CLOSED with motors 0.
- Reset mid-motion: rst=1 during CLOSING with motor_close=1 -> next cycle CLOSED, all motors 0, fault=0, reopen_cnt=0; simultaneous obstruct and lim_closed in CLOSING -> OPENING.
